// File: rtl/fetch_queue.sv
// fetch_queue -- instruction fetch queue between instruction memory and decode.
//
// Issues one read per cycle to a single-cycle-latency instruction memory while
// there is room for the returning word. Each returned word is buffered together
// with its byte address in a DEPTH-entry circular buffer. Decode pops the head.
// A redirect flushes the buffer, drops any response still in flight, and
// restarts fetching at redirect_pc.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst          asynchronous active-high reset
//   imem_req     read request to instruction memory this cycle
//   imem_addr    byte address of the request (the pc register)
//   imem_rdata   instruction word returned one cycle after an accepted request
//   redirect     flush and restart fetching at redirect_pc
//   redirect_pc  new fetch address, sampled when redirect=1
//   deq          decode consumes the head entry this cycle
//   valid_out    head entry is valid
//   inst_out     head instruction word
//   pc_out       byte address of the head instruction
//   count        number of occupied entries
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_req,
  output logic [31:0]              imem_addr,
  input  logic [31:0]              imem_rdata,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  input  logic                     deq,
  output logic                     valid_out,
  output logic [31:0]              inst_out,
  output logic [31:0]              pc_out,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  // DEPTH is a power of two, so the natural wrap of the pointer width
  // implements modulo-DEPTH advance.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return p + 1'b1;
  endfunction

  logic [31:0]      pc;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic             inflight;
  logic [31:0]      inflight_pc;
  logic [31:0]      mem_pc   [DEPTH];
  logic [31:0]      mem_inst [DEPTH];

  logic [CNT_W-1:0] occ;
  logic             enq;
  logic             deq_ok;

  // A slot is reserved for the word already in flight; a same-cycle deq
  // earns no credit so the request decision stays off the decode path.
  assign occ       = count + CNT_W'(inflight);
  assign imem_req  = !rst && !redirect && (occ < FULL);
  assign imem_addr = pc;

  // A response arriving in a redirect cycle belongs to the squashed stream.
  assign enq    = inflight && !redirect;
  assign deq_ok = deq && valid_out && !redirect;

  assign valid_out = (count != '0);
  assign inst_out  = mem_inst[head];
  assign pc_out    = mem_pc[head];

  // ---- request stage -> response stage boundary (control) ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= RESET_PC;
      count    <= '0;
      head     <= '0;
      tail     <= '0;
      inflight <= 1'b0;
    end else if (redirect) begin
      pc       <= redirect_pc;
      count    <= '0;
      head     <= '0;
      tail     <= '0;
      inflight <= 1'b0;
    end else begin
      if (imem_req) pc <= pc + 32'd4;
      inflight <= imem_req;
      if (enq)    tail <= ptr_inc(tail);
      if (deq_ok) head <= ptr_inc(head);
      case ({enq, deq_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ---- request stage -> response stage boundary (data, no reset) ----
  always_ff @(posedge clk) begin
    if (imem_req) inflight_pc <= pc;
    if (enq) begin
      mem_pc[tail]   <= inflight_pc;
      mem_inst[tail] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Testbench for fetch_queue: directed scenarios followed by randomized traffic,
// every cycle compared against a queue-based reference model.
module tb_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        deq;
  logic        valid_out;
  logic [31:0] inst_out;
  logic [31:0] pc_out;
  logic [$clog2(DEPTH):0] count;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .deq         (deq),
    .valid_out   (valid_out),
    .inst_out    (inst_out),
    .pc_out      (pc_out),
    .count       (count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Instruction memory contents: a word derived from its address.
  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, ~a[31:16]};
  endfunction

  // Reference model: program-order queue of fetched words, one pending
  // memory read, and the next fetch address.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t        mq[$];
  bit          m_pend;
  logic [31:0] m_pend_pc;
  logic [31:0] mpc;

  task automatic model_reset();
    mq.delete();
    m_pend    = 1'b0;
    m_pend_pc = '0;
    mpc       = RESET_PC;
  endtask

  // One clock cycle: drive inputs at the falling edge, check outputs shortly
  // after, then advance the model across the following rising edge.
  task automatic step(input bit r, input bit d, input bit rd, input logic [31:0] rpc);
    bit   exp_req;
    bit   dq;
    ent_t e;
    @(negedge clk);
    rst         = r;
    deq         = d;
    redirect    = rd;
    redirect_pc = rpc;
    imem_rdata  = m_pend ? inst_of(m_pend_pc) : $urandom();
    if (r) model_reset();
    #1;
    exp_req = !r && !rd && ((mq.size() + int'(m_pend)) < DEPTH);
    chk("imem_req",  32'(imem_req),  32'(exp_req));
    chk("imem_addr", imem_addr,      mpc);
    chk("valid_out", 32'(valid_out), 32'(mq.size() != 0));
    chk("count",     32'(count),     mq.size());
    if (mq.size() != 0) begin
      chk("pc_out",   pc_out,   mq[0].pc);
      chk("inst_out", inst_out, mq[0].inst);
    end
    if (!r) begin
      if (rd) begin
        mq.delete();
        m_pend = 1'b0;
        mpc    = rpc;
      end else begin
        dq = d && (mq.size() != 0);
        if (m_pend) begin
          e.pc   = m_pend_pc;
          e.inst = inst_of(m_pend_pc);
          mq.push_back(e);
        end
        if (dq) void'(mq.pop_front());
        m_pend = exp_req;
        if (exp_req) begin
          m_pend_pc = mpc;
          mpc       = mpc + 32'd4;
        end
      end
    end
  endtask

  initial begin
    int mode;
    bit r, d, rd;
    logic [31:0] rpc;

    rst = 1'b1; deq = 1'b0; redirect = 1'b0; redirect_pc = '0; imem_rdata = '0;
    model_reset();

    // Reset held for a few cycles.
    repeat (3) step(1, 0, 0, 32'h0);

    // Fill from reset with no dequeue: requests 0,4,8,12 then stall at full.
    repeat (8) step(0, 0, 0, 32'h0);
    // One dequeue from a full queue, then refill.
    step(0, 1, 0, 32'h0);
    repeat (4) step(0, 0, 0, 32'h0);
    step(0, 1, 0, 32'h0);
    repeat (3) step(0, 0, 0, 32'h0);

    // Asynchronous reset mid-fill (count=2, one word in flight).
    step(1, 0, 0, 32'h0);
    repeat (3) step(0, 0, 0, 32'h0);
    step(1, 0, 0, 32'h0);

    // Continuous dequeue from reset release: one instruction per cycle.
    repeat (14) step(0, 1, 0, 32'h0);

    // Redirect with count=3 and a response in flight.
    step(1, 0, 0, 32'h0);
    repeat (4) step(0, 0, 0, 32'h0);
    step(0, 0, 1, 32'h0000_0100);
    repeat (5) step(0, 0, 0, 32'h0);

    // Redirect and dequeue together with count=2.
    step(1, 0, 0, 32'h0);
    repeat (3) step(0, 0, 0, 32'h0);
    step(0, 1, 1, 32'h0000_0200);
    repeat (4) step(0, 1, 0, 32'h0);

    // Address wrap past 2^32.
    step(0, 0, 1, 32'hFFFF_FFF8);
    repeat (8) step(0, 1, 0, 32'h0);

    // Randomized traffic with varying dequeue pressure.
    mode = 0;
    for (int i = 0; i < 3000; i++) begin
      if ((i % 64) == 0) mode = $urandom_range(0, 3);
      r  = ($urandom_range(0, 299) == 0);
      rd = ($urandom_range(0, 15) == 0);
      case (mode)
        0:       d = 1'b0;
        1:       d = ($urandom_range(0, 9) < 3);
        2:       d = ($urandom_range(0, 9) < 7);
        default: d = 1'b1;
      endcase
      rpc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF4 : ($urandom() & 32'hFFFF_FFFC);
      step(r, d, rd, rpc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
